// File: rtl/ppu_types_pkg.sv
// Shared PPU type definitions: the four LCD controller modes as reported in STAT[1:0].
package ppu_types_pkg;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } ppu_mode_t;

endpackage

// File: rtl/ppu_util_pkg.sv
// Default DMG frame timing constants and the combined STAT interrupt line function.
package ppu_util_pkg;
  import ppu_types_pkg::*;

  localparam int DEF_DOTS_PER_LINE   = 456;
  localparam int DEF_MODE2_LEN       = 80;
  localparam int DEF_MODE3_MAX       = 289;
  localparam int DEF_VISIBLE_LINES   = 144;
  localparam int DEF_LINES_PER_FRAME = 154;

  // stat_en is {lyc, mode2, mode1, mode0}, matching STAT[6:3].
  function automatic logic stat_line_f(input logic [3:0] stat_en,
                                       input logic       lyc_match,
                                       input ppu_mode_t  mode);
    return (stat_en[3] & lyc_match)
         | (stat_en[2] & (mode == MODE_2))
         | (stat_en[1] & (mode == MODE_1))
         | (stat_en[0] & (mode == MODE_0));
  endfunction

endpackage

// File: rtl/ppu_timing_ctrl_if.sv
// Control/status bundle between the PPU timing block (slave) and the CPU/renderer side (master).
interface ppu_timing_ctrl_if
  import ppu_types_pkg::*;
#(
  parameter int DOT_W = 9
);
  logic             lcd_en;
  logic [3:0]       stat_en;
  logic [7:0]       lyc;
  logic             line_done;
  logic [DOT_W-1:0] dot;
  logic [7:0]       ly;
  ppu_mode_t        mode;
  logic             lyc_match;
  logic             flush;
  logic             vblank_req;
  logic             stat_req;
  logic             m3_timeout;

  modport master (
    output lcd_en, stat_en, lyc, line_done,
    input  dot, ly, mode, lyc_match, flush, vblank_req, stat_req, m3_timeout
  );

  modport slave (
    input  lcd_en, stat_en, lyc, line_done,
    output dot, ly, mode, lyc_match, flush, vblank_req, stat_req, m3_timeout
  );

endinterface

// File: rtl/stat_irq_gen.sv
// STAT interrupt request: rising-edge detector on the OR of all enabled STAT sources.
module stat_irq_gen
  import ppu_types_pkg::*;
  import ppu_util_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       lcd_en,
  input  logic [3:0] stat_en,
  input  logic       lyc_match,
  input  ppu_mode_t  mode,
  output logic       stat_req
);

  logic stat_line;
  logic stat_line_q;
  logic stat_req_q;

  assign stat_line = stat_line_f(stat_en, lyc_match, mode);
  assign stat_req  = stat_req_q;

  // A source that rises while another keeps the line high produces no new request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_line_q <= 1'b0;
      stat_req_q  <= 1'b0;
    end else if (!lcd_en) begin
      stat_line_q <= 1'b0;
      stat_req_q  <= 1'b0;
    end else begin
      stat_line_q <= stat_line;
      stat_req_q  <= stat_line & ~stat_line_q;
    end
  end

endmodule

// File: rtl/ppu_timing_ctrl.sv
// PPU dot/line/mode sequencer with LYC compare, VBlank/STAT pulses and mode-3 watchdog.
// Optional PPU_LY153_QUIRK_EN: ly (and lyc_match) read 0 from dot 4 of the last frame line.
module ppu_timing_ctrl
  import ppu_types_pkg::*;
  import ppu_util_pkg::*;
#(
  parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
  parameter int MODE2_LEN       = DEF_MODE2_LEN,
  parameter int MODE3_MAX       = DEF_MODE3_MAX,
  parameter int VISIBLE_LINES   = DEF_VISIBLE_LINES,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int DOT_W           = $clog2(DOTS_PER_LINE)
) (
  input logic              clk,
  input logic              reset_n,
  ppu_timing_ctrl_if.slave bus
);

  localparam logic [DOT_W-1:0] DOT_LAST   = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [DOT_W-1:0] M2_LAST    = DOT_W'(MODE2_LEN - 1);
  localparam logic [DOT_W-1:0] M3_LAST    = DOT_W'(MODE2_LEN + MODE3_MAX - 1);
  localparam logic [7:0]       VIS_LAST   = 8'(VISIBLE_LINES - 1);
  localparam logic [7:0]       FRAME_LAST = 8'(LINES_PER_FRAME - 1);

  if (MODE2_LEN + MODE3_MAX >= DOTS_PER_LINE) begin : g_chk_mode3
    $error("ppu_timing_ctrl: MODE2_LEN+MODE3_MAX must be below DOTS_PER_LINE");
  end
  if (LINES_PER_FRAME > 256) begin : g_chk_lines
    $error("ppu_timing_ctrl: LINES_PER_FRAME must not exceed 256");
  end

  logic [DOT_W-1:0] dot_q, dot_d;
  logic [7:0]       line_q, line_d;
  logic [7:0]       ly_q, ly_d;
  ppu_mode_t        mode_q, mode_d;
  logic             lyc_match_q;
  logic             flush_q, flush_d;
  logic             vblank_q, vblank_d;
  logic             m3_timeout_q, m3_timeout_d;
  logic             lcd_on_q;
  logic             end_of_line;
  logic             stat_req;

  assign end_of_line = (dot_q == DOT_LAST);

  // Counters restart on the first enabled cycle after the LCD was off.
  always_comb begin
    dot_d  = dot_q + DOT_W'(1);
    line_d = line_q;
    if (!bus.lcd_en || !lcd_on_q) begin
      dot_d  = '0;
      line_d = '0;
    end else if (end_of_line) begin
      dot_d  = '0;
      line_d = (line_q == FRAME_LAST) ? 8'd0 : line_q + 8'd1;
    end
    ly_d = line_d;
`ifdef PPU_LY153_QUIRK_EN
    if (line_d == FRAME_LAST && dot_d >= DOT_W'(4)) ly_d = 8'd0;
`endif
  end

  always_comb begin
    mode_d       = mode_q;
    flush_d      = 1'b0;
    vblank_d     = 1'b0;
    m3_timeout_d = m3_timeout_q;
    if (!bus.lcd_en) begin
      mode_d = MODE_0;
    end else if (!lcd_on_q) begin
      mode_d = MODE_2;
    end else begin
      case (mode_q)
        MODE_2: if (dot_q == M2_LAST) begin
          mode_d  = MODE_3;
          flush_d = 1'b1;
        end
        MODE_3: if (bus.line_done) begin
          mode_d = MODE_0;
        end else if (dot_q == M3_LAST) begin
          mode_d       = MODE_0;
          m3_timeout_d = 1'b1;
        end
        MODE_0: if (end_of_line) begin
          if (line_q == VIS_LAST) begin
            mode_d   = MODE_1;
            vblank_d = 1'b1;
          end else begin
            mode_d = MODE_2;
          end
        end
        MODE_1: if (end_of_line && line_q == FRAME_LAST) mode_d = MODE_2;
        default: mode_d = MODE_0;
      endcase
    end
  end

  // lyc_match compares against the ly being loaded so it stays coherent across line boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dot_q        <= '0;
      line_q       <= '0;
      ly_q         <= '0;
      mode_q       <= MODE_2;
      lyc_match_q  <= 1'b0;
      flush_q      <= 1'b0;
      vblank_q     <= 1'b0;
      m3_timeout_q <= 1'b0;
      lcd_on_q     <= 1'b1;
    end else begin
      dot_q        <= dot_d;
      line_q       <= line_d;
      ly_q         <= ly_d;
      mode_q       <= mode_d;
      lyc_match_q  <= (ly_d == bus.lyc);
      flush_q      <= flush_d;
      vblank_q     <= vblank_d;
      m3_timeout_q <= m3_timeout_d;
      lcd_on_q     <= bus.lcd_en;
    end
  end

  stat_irq_gen u_stat_irq_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .lcd_en    (bus.lcd_en),
    .stat_en   (bus.stat_en),
    .lyc_match (lyc_match_q),
    .mode      (mode_q),
    .stat_req  (stat_req)
  );

  assign bus.dot        = dot_q;
  assign bus.ly         = ly_q;
  assign bus.mode       = mode_q;
  assign bus.lyc_match  = lyc_match_q;
  assign bus.flush      = flush_q;
  assign bus.vblank_req = vblank_q;
  assign bus.stat_req   = stat_req;
  assign bus.m3_timeout = m3_timeout_q;

endmodule

// File: tb/tb_ppu_timing_ctrl.sv
// Directed bench for ppu_timing_ctrl on a 456-dot, 10-line frame (8 visible lines).
module tb_ppu_timing_ctrl;
  import ppu_types_pkg::*;

  localparam int DPL   = 456;
  localparam int LPF   = 10;
  localparam int DOT_W = 9;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stat_cnt = 0;
  int   vbl_cnt = 0;
  logic use_ld = 1'b1;
  logic quirk;

  ppu_timing_ctrl_if #(.DOT_W(DOT_W)) bus ();

  ppu_timing_ctrl #(
    .DOTS_PER_LINE   (DPL),
    .MODE2_LEN       (80),
    .MODE3_MAX       (289),
    .VISIBLE_LINES   (8),
    .LINES_PER_FRAME (LPF),
    .DOT_W           (DOT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; renderer model finishes the line at dot 252.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.line_done = use_ld && (bus.dot == DOT_W'(252));
      stat_cnt += int'(bus.stat_req);
      vbl_cnt  += int'(bus.vblank_req);
    end
  endtask

  task automatic gotoPos(input int frame, input int line, input int d);
    int target;
    target = (frame * LPF + line) * DPL + d;
    if (target < cyc) checkOutput("goto_order", cyc, target);
    while (cyc < target) applyStimulus(1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_dot"}, bus.dot, 0);
    checkOutput({tag, "_ly"}, bus.ly, 0);
    checkOutput({tag, "_mode"}, bus.mode, MODE_2);
    checkOutput({tag, "_lyc_match"}, bus.lyc_match, 0);
    checkOutput({tag, "_flush"}, bus.flush, 0);
    checkOutput({tag, "_vblank"}, bus.vblank_req, 0);
    checkOutput({tag, "_stat_req"}, bus.stat_req, 0);
    checkOutput({tag, "_m3_timeout"}, bus.m3_timeout, 0);
  endtask

  initial begin
`ifdef PPU_LY153_QUIRK_EN
    quirk = 1'b1;
`else
    quirk = 1'b0;
`endif
    reset_n       = 1'b0;
    bus.lcd_en    = 1'b1;
    bus.stat_en   = 4'b1001;
    bus.lyc       = 8'd5;
    bus.line_done = 1'b0;
    #12;
    checkResetValues("reset");
    reset_n = 1'b1;
    cyc = 0;

    // Mode 2 -> 3 with flush, line_done exit, line advance
    applyStimulus(79);
    checkOutput("m2_last_mode", bus.mode, MODE_2);
    checkOutput("m2_last_flush", bus.flush, 0);
    applyStimulus(1);
    checkOutput("m3_entry_dot", bus.dot, 80);
    checkOutput("m3_entry_mode", bus.mode, MODE_3);
    checkOutput("m3_entry_flush", bus.flush, 1);
    applyStimulus(1);
    checkOutput("flush_one_cycle", bus.flush, 0);
    gotoPos(0, 0, 252);
    checkOutput("m3_at_252", bus.mode, MODE_3);
    applyStimulus(1);
    checkOutput("m0_at_253", bus.mode, MODE_0);
    gotoPos(0, 0, 455);
    checkOutput("eol_ly", bus.ly, 0);
    checkOutput("eol_dot", bus.dot, 455);
    applyStimulus(1);
    checkOutput("l1_ly", bus.ly, 1);
    checkOutput("l1_dot", bus.dot, 0);
    checkOutput("l1_mode", bus.mode, MODE_2);

    // Mode0 enable then LYC=5: one request on line 4 HBlank, none at line 5 start
    gotoPos(0, 4, 0);
    stat_cnt = 0;
    gotoPos(0, 4, 253);
    checkOutput("l4_stat_before", bus.stat_req, 0);
    applyStimulus(1);
    checkOutput("l4_stat_pulse", bus.stat_req, 1);
    gotoPos(0, 5, 455);
    checkOutput("l4_l5_stat_count", stat_cnt, 1);

    // VBlank entry
    gotoPos(0, 7, 455);
    checkOutput("l7_mode", bus.mode, MODE_0);
    vbl_cnt = 0;
    applyStimulus(1);
    checkOutput("vbl_ly", bus.ly, 8);
    checkOutput("vbl_mode", bus.mode, MODE_1);
    checkOutput("vbl_pulse", bus.vblank_req, 1);
    applyStimulus(1);
    checkOutput("vbl_one_cycle", bus.vblank_req, 0);

    // LYC=0 with only the LYC source enabled, across the frame wrap
    gotoPos(0, 8, 10);
    bus.stat_en = 4'b1000;
    bus.lyc     = 8'd0;
    stat_cnt    = 0;
    gotoPos(0, 9, 3);
    checkOutput("l9_d3_ly", bus.ly, 9);
    applyStimulus(1);
    checkOutput("l9_d4_ly", bus.ly, quirk ? 0 : 9);
    applyStimulus(1);
    checkOutput("l9_d5_stat", bus.stat_req, quirk ? 1 : 0);
    gotoPos(0, 9, 455);
    checkOutput("l9_mode", bus.mode, MODE_1);
    checkOutput("frame_vbl_count", vbl_cnt, 1);
    applyStimulus(1);
    checkOutput("wrap_ly", bus.ly, 0);
    checkOutput("wrap_mode", bus.mode, MODE_2);
    checkOutput("wrap_d0_stat", bus.stat_req, 0);
    applyStimulus(1);
    checkOutput("wrap_d1_stat", bus.stat_req, quirk ? 0 : 1);
    use_ld = 1'b0;
    gotoPos(1, 0, 300);
    checkOutput("lyc0_stat_count", stat_cnt, 1);

    // Mode-3 watchdog
    gotoPos(1, 0, 368);
    checkOutput("wd_m3_mode", bus.mode, MODE_3);
    checkOutput("wd_m3_flag", bus.m3_timeout, 0);
    applyStimulus(1);
    checkOutput("wd_exit_mode", bus.mode, MODE_0);
    checkOutput("wd_exit_flag", bus.m3_timeout, 1);
    gotoPos(1, 1, 100);
    checkOutput("wd_sticky", bus.m3_timeout, 1);

    // LCD off forces counters, suppresses pulses, keeps m3_timeout
    bus.lcd_en = 1'b0;
    stat_cnt = 0;
    applyStimulus(3);
    checkOutput("off_dot", bus.dot, 0);
    checkOutput("off_ly", bus.ly, 0);
    checkOutput("off_mode", bus.mode, MODE_0);
    checkOutput("off_m3_hold", bus.m3_timeout, 1);
    checkOutput("off_stat_count", stat_cnt, 0);
    bus.lcd_en = 1'b1;
    applyStimulus(1);
    checkOutput("on_dot", bus.dot, 0);
    checkOutput("on_mode", bus.mode, MODE_2);
    cyc = 0;
    applyStimulus(1);
    checkOutput("on_dot1", bus.dot, 1);

    // Asynchronous reset in mid mode 3
    gotoPos(0, 0, 150);
    checkOutput("pre_reset_mode", bus.mode, MODE_3);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("async");
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    cyc = 0;
    checkOutput("rel_dot", bus.dot, 0);
    checkOutput("rel_mode", bus.mode, MODE_2);
    applyStimulus(1);
    checkOutput("rel_dot1", bus.dot, 1);
    applyStimulus(79);
    checkOutput("rel_m3_mode", bus.mode, MODE_3);
    checkOutput("rel_m3_flush", bus.flush, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
